// File: rtl/sus_grid_scanner.sv
// Grid event scanner: snapshots the grid on a trigger and scans one point per clock for the argmax.
// Reports the result over a valid/ready handshake. Optional macro SUS_GRID_SCANNER_TIMESTAMP_EN adds event_timestamp.
module sus_grid_scanner #(
    parameter int NUMBER_OF_BITS_OF_OUTPUT = 9,
    parameter int NUMBER_OF_GRID_POINTS    = 12,
    parameter int INDEX_WIDTH              = 4,
    parameter int HOLDOFF_CYCLES           = 16
) (
    input  logic                                                clock,
    input  logic                                                reset,
    input  logic [NUMBER_OF_GRID_POINTS*NUMBER_OF_BITS_OF_OUTPUT-1:0] grid_flat,
    input  logic [NUMBER_OF_BITS_OF_OUTPUT-1:0]                 threshold,
    input  logic                                                enable,
    output logic                                                event_valid,
    input  logic                                                event_ready,
    output logic [INDEX_WIDTH-1:0]                              event_index,
    output logic [NUMBER_OF_BITS_OF_OUTPUT-1:0]                 event_value,
    output logic                                                busy,
    output logic [15:0]                                         missed_count
`ifdef SUS_GRID_SCANNER_TIMESTAMP_EN
    ,output logic [31:0]                                        event_timestamp
`endif
);
    localparam int W   = NUMBER_OF_BITS_OF_OUTPUT;
    localparam int N   = NUMBER_OF_GRID_POINTS;
    localparam int HCW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SCAN    = 2'd1;
    localparam logic [1:0] ST_REPORT  = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [N-1:0][W-1:0]      snap_q, snap_d;
    logic [INDEX_WIDTH-1:0]   scan_idx_q, scan_idx_d;
    logic [INDEX_WIDTH-1:0]   best_idx_q, best_idx_d;
    logic [W-1:0]             best_val_q, best_val_d;
    logic [HCW-1:0]           hold_cnt_q, hold_cnt_d;
    logic [15:0]              missed_q, missed_d;
    logic [N-1:0]             above;
    logic                     trigger;

    for (genvar k = 0; k < N; k++) begin : g_cmp
        assign above[k] = grid_flat[k*W +: W] > threshold;
    end
    assign trigger = enable & (|above);

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        scan_idx_d = scan_idx_q;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        hold_cnt_d = hold_cnt_q;
        missed_d   = missed_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    snap_d     = grid_flat;
                    scan_idx_d = '0;
                    best_idx_d = '0;
                    best_val_d = grid_flat[W-1:0];
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // strict compare keeps the lowest index on ties
                if (snap_q[scan_idx_q] > best_val_q) begin
                    best_val_d = snap_q[scan_idx_q];
                    best_idx_d = scan_idx_q;
                end
                if (scan_idx_q == INDEX_WIDTH'(N-1)) state_d = ST_REPORT;
                else scan_idx_d = scan_idx_q + 1'b1;
            end
            ST_REPORT: begin
                if (event_ready) begin
                    if (HOLDOFF_CYCLES == 0) state_d = ST_IDLE;
                    else begin
                        state_d    = ST_HOLDOFF;
                        hold_cnt_d = HCW'(HOLDOFF_CYCLES - 1);
                    end
                end
            end
            default: begin
                if (hold_cnt_q == '0) state_d = ST_IDLE;
                else hold_cnt_d = hold_cnt_q - 1'b1;
            end
        endcase
        // capture only from IDLE; any other trigger is a miss, including the HOLDOFF exit edge
        if (trigger && state_q != ST_IDLE && missed_q != 16'hFFFF) missed_d = missed_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            snap_q     <= '0;
            scan_idx_q <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            hold_cnt_q <= '0;
            missed_q   <= '0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            scan_idx_q <= scan_idx_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
            hold_cnt_q <= hold_cnt_d;
            missed_q   <= missed_d;
        end
    end

`ifdef SUS_GRID_SCANNER_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d, ev_ts_q, ev_ts_d;

    always_comb begin
        ts_d    = ts_q + 32'd1;
        ev_ts_d = ev_ts_q;
        if (state_q == ST_IDLE && trigger) ev_ts_d = ts_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_q    <= '0;
            ev_ts_q <= '0;
        end else begin
            ts_q    <= ts_d;
            ev_ts_q <= ev_ts_d;
        end
    end

    assign event_timestamp = ev_ts_q;
`endif

    assign event_valid  = (state_q == ST_REPORT);
    assign event_index  = best_idx_q;
    assign event_value  = best_val_q;
    assign busy         = (state_q != ST_IDLE);
    assign missed_count = missed_q;
endmodule

// File: tb/tb_sus_grid_scanner.sv
// Directed bench for sus_grid_scanner: hand-computed vectors, immediate assertions at each check.
module tb_sus_grid_scanner;
    logic         clock = 1'b0;
    logic         reset;
    logic [107:0] grid_flat;
    logic [8:0]   threshold;
    logic         enable;
    logic         event_valid;
    logic         event_ready;
    logic [3:0]   event_index;
    logic [8:0]   event_value;
    logic         busy;
    logic [15:0]  missed_count;

    int vectors    = 0;
    int miscompares = 0;

    sus_grid_scanner dut (
        .clock        (clock),
        .reset        (reset),
        .grid_flat    (grid_flat),
        .threshold    (threshold),
        .enable       (enable),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .event_index  (event_index),
        .event_value  (event_value),
        .busy         (busy),
        .missed_count (missed_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic put(input int k, input int v);
        grid_flat[k*9 +: 9] = 9'(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept in REPORT, then expect busy for exactly 16 clocks after the handshake edge.
    task automatic accept_and_holdoff(input string tag);
        event_ready = 1'b1;
        tick();
        event_ready = 1'b0;
        chk({tag, "_hs_valid"}, 32'(event_valid), 32'd0);
        ticks(15);
        chk({tag, "_hold15_busy"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_hold16_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic rose;
        reset       = 1'b0;
        grid_flat   = '0;
        threshold   = 9'd10;
        enable      = 1'b0;
        event_ready = 1'b0;
        ticks(2);
        chk("rst_valid", 32'(event_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_index", 32'(event_index), 32'd0);
        chk("rst_value", 32'(event_value), 32'd0);
        chk("rst_missed", 32'(missed_count), 32'd0);
        reset = 1'b1;

        // single point above threshold, one clock wide
        enable = 1'b1;
        put(0, 18);
        tick();
        grid_flat = '0;
        chk("t1_busy", 32'(busy), 32'd1);
        ticks(11);
        chk("t1_valid_at11", 32'(event_valid), 32'd0);
        tick();
        chk("t1_valid_at12", 32'(event_valid), 32'd1);
        chk("t1_index", 32'(event_index), 32'd0);
        chk("t1_value", 32'(event_value), 32'd18);
        chk("t1_missed", 32'(missed_count), 32'd0);
        accept_and_holdoff("t1");

        // tie at 27 keeps lowest index; hold off ready for five clocks
        threshold = 9'd20;
        put(2, 26);
        put(4, 27);
        put(9, 27);
        tick();
        grid_flat = '0;
        ticks(12);
        chk("t2_valid", 32'(event_valid), 32'd1);
        chk("t2_index", 32'(event_index), 32'd4);
        chk("t2_value", 32'(event_value), 32'd27);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_stall_valid", 32'(event_valid), 32'd1);
            chk("t2_stall_index", 32'(event_index), 32'd4);
            chk("t2_stall_value", 32'(event_value), 32'd27);
        end
        accept_and_holdoff("t2");

        // misses during SCAN and HOLDOFF, then a trigger on the HOLDOFF exit edge
        threshold = 9'd10;
        put(7, 50);
        tick();
        tick();
        grid_flat = '0;
        chk("t3_miss_scan", 32'(missed_count), 32'd1);
        ticks(11);
        chk("t3_valid", 32'(event_valid), 32'd1);
        chk("t3_index", 32'(event_index), 32'd7);
        chk("t3_value", 32'(event_value), 32'd50);
        event_ready = 1'b1;
        tick();
        event_ready = 1'b0;
        put(1, 99);
        tick();
        grid_flat = '0;
        chk("t3_miss_hold", 32'(missed_count), 32'd2);
        ticks(14);
        chk("t3_h15_busy", 32'(busy), 32'd1);
        put(1, 99);
        tick();
        grid_flat = '0;
        chk("t3_exit_busy", 32'(busy), 32'd0);
        chk("t3_exit_missed", 32'(missed_count), 32'd3);
        tick();
        chk("t3_no_capture", 32'(busy), 32'd0);

        // equality does not trigger; disabled input does not trigger
        put(5, 10);
        ticks(3);
        chk("t4_eq_busy", 32'(busy), 32'd0);
        put(5, 200);
        enable = 1'b0;
        ticks(2);
        chk("t4_dis_busy", 32'(busy), 32'd0);
        chk("t4_missed", 32'(missed_count), 32'd3);
        grid_flat = '0;
        enable = 1'b1;

        // reset mid-scan at scan_index 6 discards the event
        put(3, 40);
        tick();
        grid_flat = '0;
        ticks(6);
        reset = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_valid", 32'(event_valid), 32'd0);
        chk("t5_rst_index", 32'(event_index), 32'd0);
        chk("t5_rst_value", 32'(event_value), 32'd0);
        chk("t5_rst_missed", 32'(missed_count), 32'd0);
        put(11, 100);
        ticks(2);
        chk("t5_rst_hold_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();
        chk("t5_first_edge_capture", 32'(busy), 32'd1);
        grid_flat = '0;
        enable = 1'b0;
        rose = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (event_valid) rose = 1'b1;
        end
        chk("t5_no_early_valid", 32'(rose), 32'd0);
        tick();
        chk("t5_valid", 32'(event_valid), 32'd1);
        chk("t5_index", 32'(event_index), 32'd11);
        chk("t5_value", 32'(event_value), 32'd100);
        chk("t5_missed", 32'(missed_count), 32'd0);
        accept_and_holdoff("t5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sus_grid_scanner.md
SUS_GRID_SCANNER -- requirements
Module: sus_grid_scanner

Interface
REQ-001 The block SHALL have parameter NUMBER_OF_BITS_OF_OUTPUT, default 9, giving the width of one grid value.
REQ-002 The block SHALL have parameter NUMBER_OF_GRID_POINTS, default 12, giving the number of grid points scanned.
REQ-003 The block SHALL have parameter INDEX_WIDTH, default 4, giving the width of the grid index.
REQ-004 The block SHALL have parameter HOLDOFF_CYCLES, default 16, giving the dead time in clocks after each reported event.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port grid_flat, input, NUMBER_OF_GRID_POINTS*NUMBER_OF_BITS_OF_OUTPUT bits: grid point k at bits [k*9+8:k*9], with k=0..11 in order 0_0_0, 0_1_0, 0_2_0, 1_0_0, ... 3_2_0.
REQ-008 The block SHALL have port threshold, input, 9 bits: trigger level.
REQ-009 The block SHALL have port enable, input, 1 bit: arms triggering.
REQ-010 The block SHALL have port event_valid, output, 1 bit: result available.
REQ-011 The block SHALL have port event_ready, input, 1 bit: consumer accepts the result.
REQ-012 The block SHALL have port event_index, output, INDEX_WIDTH bits: argmax grid point.
REQ-013 The block SHALL have port event_value, output, 9 bits: maximum value.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 The block SHALL have port missed_count, output, 16 bits: count of triggers that arrived while the block was busy.

Function
REQ-016 The block SHALL implement four states, IDLE, SCAN, REPORT and HOLDOFF, in one-hot or binary encoding.
REQ-017 A trigger SHALL be defined as enable=1 and at least one grid point strictly greater than threshold; equality SHALL NOT trigger.
REQ-018 In IDLE, on a trigger the block SHALL capture all 12 grid values into a snapshot register on the same edge, set scan_index=0, and enter SCAN.
REQ-019 In SCAN the block SHALL compare one snapshot entry per clock, index 0..11, and replace the running best only when the entry is strictly greater, so ties keep the lowest index.
REQ-020 The running best SHALL initialise to snapshot entry 0 with index 0.
REQ-021 After the edge that processes index 11, the block SHALL enter REPORT, with event_valid rising 12 clocks after the capture edge.
REQ-022 In REPORT, event_valid, event_index and event_value SHALL hold stable until a clock edge with event_ready=1; that edge completes the handshake and enters HOLDOFF.
REQ-023 event_ready SHALL be ignored outside REPORT, and event_valid SHALL be 0 outside REPORT.
REQ-024 HOLDOFF SHALL last exactly HOLDOFF_CYCLES clocks, then return to IDLE; if HOLDOFF_CYCLES=0, the block SHALL return to IDLE directly from REPORT.
REQ-025 Any trigger condition seen in SCAN, REPORT or HOLDOFF SHALL increment missed_count, which saturates at 16'hFFFF.
REQ-026 Deasserting enable mid-event SHALL NOT abort the event; it SHALL only block new captures.
REQ-027 A trigger on the same edge that HOLDOFF returns to IDLE SHALL count as missed; capture SHALL require the state to be IDLE at that edge.

Reset
REQ-028 While reset=0, the block SHALL immediately force: state=IDLE, event_valid=0, event_index=0, event_value=0, busy=0, missed_count=0, snapshot=0, holdoff counter=0.
REQ-029 Reset asserted mid-SCAN or mid-REPORT SHALL discard the pending event without any handshake.
REQ-030 The first capture after reset deassertion SHALL be possible on the first rising edge.

Configuration
REQ-031 With macro SUS_GRID_SCANNER_TIMESTAMP_EN defined, the block SHALL add a 32-bit free-running counter (reset to 0, wrapping) and an output event_timestamp[31:0] holding the counter value at the capture edge, stable through REPORT.
REQ-032 Without SUS_GRID_SCANNER_TIMESTAMP_EN, the event_timestamp port and the counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 The bench SHALL apply threshold=10 and grid 0_0_0=18 for 1 clock, others 0 -> event_valid 12 clocks later, index=0, value=18, missed_count=0.
REQ-034 The bench SHALL apply grid points 4 and 9 both =27 and point 2 =26, threshold=20 -> index=4, value=27.
REQ-035 The bench SHALL hold event_ready low for 5 clocks in REPORT -> outputs unchanged for all 5; accept on the 6th -> busy stays high 16 more clocks, then IDLE.
REQ-036 The bench SHALL apply a second trigger during HOLDOFF and another during SCAN -> missed_count=2, only one event reported.
REQ-037 The bench SHALL apply grid max equal to threshold (value 10) -> no capture, busy stays 0.
REQ-038 The bench SHALL assert reset low at scan_index 6 -> event_valid never rises, all outputs 0; a new trigger after release -> normal event.
